multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle successor to the single-cycle MIPS control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back, stalling on a ready/valid memory handshake. It sits between the instruction register and the shared datapath (PC, register bank, ALU, unified memory, HI/LO divider), driving the same `pc_src`/`reg_dst`/`alu_op` encodings. It adds behaviour the single-cycle unit lacks: multi-cycle DIV with HI/LO write, memory wait-state handling with timeout, and illegal-instruction trapping.

## Interface
Parameters:
- `OPCODE_W`, 6: opcode field width.
- `FUNCT_W`, 6: funct field width.
- `ALUOP_W`, 3: ALU operation code width.
- `DIV_CYCLES`, 32: divider latency in cycles, ≥2.
- `MEM_TIMEOUT`, 15: maximum wait cycles for `mem_ready`, ≥1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `opcode`, in, `OPCODE_W`: from the IR, stable from DECODE onward.
- `funct`, in, `FUNCT_W`: from the IR.
- `zero`, in, 1: ALU zero flag.
- `mem_ready`, in, 1: memory completes the current access this cycle.
- `pc_write`, out, 1: PC load enable.
- `pc_src`, out, 2: 00 branch target, 01 jump target, 10 rs, 11 PC+1.
- `ir_write`, out, 1: IR load enable.
- `reg_dst`, out, 2: 0 rt, 1 rd, 2 $ra.
- `mem_to_reg`, out, 1: write-back source is memory.
- `alu_op`, out, `ALUOP_W`: 000 add, 001 sub (beq), 010 and, 100 or, 101 xor, 110 funct-decoded, 111 sub (bne).
- `alu_src_b`, out, 1: 1 selects the immediate.
- `mem_read`, out, 1: memory read request.
- `mem_write`, out, 1: memory write request.
- `reg_write`, out, 1: register bank write enable.
- `div_start`, out, 1: one-cycle divider start pulse.
- `hilo_write`, out, 1: HI/LO load enable.
- `illegal_instr`, out, 1: one-cycle trap pulse.
- `bus_error`, out, 1: one-cycle memory timeout pulse.

## Operation
- States: RST, FETCH, DECODE, R_EXEC, I_EXEC, BRANCH, JUMP, JREG, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, DIV_WAIT, TRAP.
- RST: all outputs 0. Next state is FETCH.
- FETCH: `mem_read`=1. On `mem_ready`, assert `ir_write`, `pc_write` and `pc_src`=11, then go to DECODE.
- DECODE: all outputs 0. Branch on opcode/funct:
  - R (opcode 0, funct not JR/JALR/DIV) → R_EXEC.
  - ADDI/ANDI/ORI/XORI → I_EXEC.
  - LW/SW → MEM_ADDR.
  - BEQ/BNE → BRANCH.
  - J/JAL → JUMP.
  - JR/JALR → JREG.
  - DIV → DIV_WAIT with `div_start`=1.
  - SPECIAL2 MUL → R_EXEC.
  - Anything else → TRAP.
- R_EXEC: `alu_op`=110, `alu_src_b`=0. Next WB_ALU with `reg_dst`=1.
- I_EXEC: `alu_src_b`=1; `alu_op` is add, and, or or xor per opcode. Next WB_ALU with `reg_dst`=0.
- WB_ALU: `reg_write`=1, `mem_to_reg`=0; `alu_op`/`alu_src_b` held from the preceding state. Next FETCH.
- BRANCH: `alu_op` 001 (BEQ) or 111 (BNE). `pc_src`=00 and `pc_write` = `zero` (BEQ) or `!zero` (BNE). Next FETCH.
- JUMP: `pc_write`=1, `pc_src`=01. JAL also asserts `reg_write`=1 with `reg_dst`=2. Next FETCH.
- JREG: `pc_write`=1, `pc_src`=10. JALR also asserts `reg_write` with `reg_dst`=2. Next FETCH.
- MEM_ADDR: `alu_op`=000, `alu_src_b`=1. Next MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: hold `mem_read`=1 until `mem_ready`. Next WB_MEM.
- WB_MEM: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next FETCH.
- MEM_WR: hold `mem_write`=1 until `mem_ready`. Next FETCH.
- DIV_WAIT: counter runs 0..DIV_CYCLES-1. At the terminal count, assert `hilo_write`=1, then go to FETCH.
- TRAP: `illegal_instr`=1 for one cycle. Next FETCH; the PC has already advanced, so the instruction is skipped.
- Memory timeout:
  - A wait counter runs in FETCH/MEM_RD/MEM_WR while `mem_ready`=0, and clears on state entry.
  - If it reaches MEM_TIMEOUT without `mem_ready`, drop the request, pulse `bus_error` and go to TRAP, which also pulses `illegal_instr`.
  - If `mem_ready` arrives on the same cycle as the timeout, ready wins: no error.

## Timing
- Outputs are a combinational decode of the state register, plus `zero` (BRANCH) and `mem_ready` (FETCH strobes).
- Reset:
  - Asynchronous entry to RST; all outputs 0; both counters cleared.
  - After reset release: one cycle in RST, then FETCH.
  - Reset mid-instruction aborts it: no further writes.
- Cycles per instruction with zero-wait memory (`mem_ready` high in the first request cycle):
  - Branch, J/JAL, JR/JALR: 3.
  - ALU ops and SW: 4.
  - LW: 5.
  - DIV: 2 + DIV_CYCLES.
- Each memory wait cycle adds 1.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - opcode/funct constants;
  - `pc_src`, `reg_dst` and `alu_op` encodings;
  - state enum.
- Sub-module `instr_class_decoder`: combinational opcode/funct → instruction class plus immediate-ALU op. It is used by DECODE and I_EXEC.

## Test plan
- ADDI (opcode 001000), `mem_ready` always 1:
  - FETCH→DECODE→I_EXEC→WB_ALU→FETCH;
  - `reg_write`=1 only in WB_ALU, with `reg_dst`=0 and `alu_src_b`=1.
- LW with `mem_ready` delayed 3 cycles in MEM_RD: `mem_read` held 4 cycles; `mem_to_reg`=1 and `reg_write`=1 one cycle later; 8 cycles total.
- BEQ with `zero`=1, then BNE with `zero`=1: `pc_write`=1 with `pc_src`=00 for BEQ; `pc_write`=0 for BNE.
- DIV (funct 011010), DIV_CYCLES=4: `div_start` pulse in DECODE; `hilo_write` exactly 4 cycles later; `reg_write` never asserted.
- Opcode 111111: single `illegal_instr` pulse, no writes, back in FETCH.
- `mem_ready` held 0 in FETCH with MEM_TIMEOUT=15:
  - after 15 wait cycles, `bus_error` pulses, then `illegal_instr`;
  - assert `rst_n`=0 mid-DIV_WAIT → all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings, opcodes and FSM states for the multi-cycle control unit
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_XORI     = 6'b001110;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;

    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_MUL  = 6'b000010;

    localparam logic [1:0] PC_SRC_BRANCH = 2'b00;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
    localparam logic [1:0] PC_SRC_RS     = 2'b10;
    localparam logic [1:0] PC_SRC_PC1    = 2'b11;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_XOR   = 3'b101;
    localparam logic [2:0] ALU_FUNCT = 3'b110;
    localparam logic [2:0] ALU_SUBN  = 3'b111;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_JALR,
        CLS_DIV,
        CLS_ILLEGAL
    } instr_class_e;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_R_EXEC,
        S_I_EXEC,
        S_BRANCH,
        S_JUMP,
        S_JREG,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_DIV_WAIT,
        S_TRAP
    } state_e;

endpackage

// File: rtl/instr_class_decoder.sv
// rtl/instr_class_decoder.sv - combinational opcode/funct to instruction class and immediate ALU op
module instr_class_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUOP_W  = 3
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output instr_class_e        instr_class,
    output logic [ALUOP_W-1:0]  imm_alu_op
);

    always_comb begin
        instr_class = CLS_ILLEGAL;
        imm_alu_op  = ALUOP_W'(ALU_ADD);
        case (opcode)
            OPCODE_W'(OP_RTYPE): begin
                if (funct == FUNCT_W'(F_JR)) begin
                    instr_class = CLS_JR;
                end else if (funct == FUNCT_W'(F_JALR)) begin
                    instr_class = CLS_JALR;
                end else if (funct == FUNCT_W'(F_DIV)) begin
                    instr_class = CLS_DIV;
                end else begin
                    instr_class = CLS_R;
                end
            end
            // Only MUL is implemented from the SPECIAL2 space; other functs trap.
            OPCODE_W'(OP_SPECIAL2): begin
                if (funct == FUNCT_W'(F_MUL)) begin
                    instr_class = CLS_R;
                end
            end
            OPCODE_W'(OP_ADDI): begin
                instr_class = CLS_IMM;
                imm_alu_op  = ALUOP_W'(ALU_ADD);
            end
            OPCODE_W'(OP_ANDI): begin
                instr_class = CLS_IMM;
                imm_alu_op  = ALUOP_W'(ALU_AND);
            end
            OPCODE_W'(OP_ORI): begin
                instr_class = CLS_IMM;
                imm_alu_op  = ALUOP_W'(ALU_OR);
            end
            OPCODE_W'(OP_XORI): begin
                instr_class = CLS_IMM;
                imm_alu_op  = ALUOP_W'(ALU_XOR);
            end
            OPCODE_W'(OP_LW):  instr_class = CLS_LOAD;
            OPCODE_W'(OP_SW):  instr_class = CLS_STORE;
            OPCODE_W'(OP_BEQ): instr_class = CLS_BEQ;
            OPCODE_W'(OP_BNE): instr_class = CLS_BNE;
            OPCODE_W'(OP_J):   instr_class = CLS_J;
            OPCODE_W'(OP_JAL): instr_class = CLS_JAL;
            default:           instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS control FSM with memory stall, divider wait and trap handling
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int FUNCT_W     = 6,
    parameter int ALUOP_W     = 3,
    parameter int DIV_CYCLES  = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                ir_write,
    output logic [1:0]          reg_dst,
    output logic                mem_to_reg,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                alu_src_b,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                div_start,
    output logic                hilo_write,
    output logic                illegal_instr,
    output logic                bus_error
);

    localparam int DIV_CNT_W  = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam int WAIT_CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [DIV_CNT_W-1:0]  DIV_LAST   = DIV_CNT_W'(DIV_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

    state_e                  state_q, state_d;
    logic [DIV_CNT_W-1:0]    div_cnt_q, div_cnt_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    instr_class_e            instr_class;
    logic [ALUOP_W-1:0]      imm_alu_op;
    logic                    mem_timeout;
    logic                    mem_state;

    instr_class_decoder #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W),
        .ALUOP_W  (ALUOP_W)
    ) u_decoder (
        .opcode      (opcode),
        .funct       (funct),
        .instr_class (instr_class),
        .imm_alu_op  (imm_alu_op)
    );

    // A late ready on the limit cycle still completes the access.
    assign mem_timeout = (wait_cnt_q == WAIT_LIMIT) && !mem_ready;
    assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_BRANCH;
        ir_write      = 1'b0;
        reg_dst       = REG_DST_RT;
        mem_to_reg    = 1'b0;
        alu_op        = ALUOP_W'(ALU_ADD);
        alu_src_b     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        div_start     = 1'b0;
        hilo_write    = 1'b0;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_read = !mem_timeout;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_PC1;
                    state_d  = S_DECODE;
                end else if (mem_timeout) begin
                    bus_error = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_DECODE: begin
                case (instr_class)
                    CLS_R:                state_d = S_R_EXEC;
                    CLS_IMM:              state_d = S_I_EXEC;
                    CLS_LOAD, CLS_STORE:  state_d = S_MEM_ADDR;
                    CLS_BEQ, CLS_BNE:     state_d = S_BRANCH;
                    CLS_J, CLS_JAL:       state_d = S_JUMP;
                    CLS_JR, CLS_JALR:     state_d = S_JREG;
                    CLS_DIV: begin
                        div_start = 1'b1;
                        state_d   = S_DIV_WAIT;
                    end
                    default:              state_d = S_TRAP;
                endcase
            end
            S_R_EXEC: begin
                alu_op  = ALUOP_W'(ALU_FUNCT);
                state_d = S_WB_ALU;
            end
            S_I_EXEC: begin
                alu_src_b = 1'b1;
                alu_op    = imm_alu_op;
                state_d   = S_WB_ALU;
            end
            // The IR is stable, so re-deriving the ALU controls holds the result steady.
            S_WB_ALU: begin
                reg_write = 1'b1;
                if (instr_class == CLS_IMM) begin
                    alu_src_b = 1'b1;
                    alu_op    = imm_alu_op;
                    reg_dst   = REG_DST_RT;
                end else begin
                    alu_op  = ALUOP_W'(ALU_FUNCT);
                    reg_dst = REG_DST_RD;
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                pc_src = PC_SRC_BRANCH;
                if (instr_class == CLS_BNE) begin
                    alu_op   = ALUOP_W'(ALU_SUBN);
                    pc_write = !zero;
                end else begin
                    alu_op   = ALUOP_W'(ALU_SUB);
                    pc_write = zero;
                end
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_JUMP;
                if (instr_class == CLS_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = REG_DST_RA;
                end
                state_d = S_FETCH;
            end
            S_JREG: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_RS;
                if (instr_class == CLS_JALR) begin
                    reg_write = 1'b1;
                    reg_dst   = REG_DST_RA;
                end
                state_d = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_op    = ALUOP_W'(ALU_ADD);
                alu_src_b = 1'b1;
                state_d   = (instr_class == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = !mem_timeout;
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (mem_timeout) begin
                    bus_error = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                reg_dst    = REG_DST_RT;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = !mem_timeout;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (mem_timeout) begin
                    bus_error = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_DIV_WAIT: begin
                if (div_cnt_q == DIV_LAST) begin
                    hilo_write = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_RST;
        endcase

        // Both counters only advance while the FSM stays put, so any state change clears them.
        div_cnt_d  = (state_q == S_DIV_WAIT && state_d == S_DIV_WAIT)
                   ? div_cnt_q + DIV_CNT_W'(1) : '0;
        wait_cnt_d = (mem_state && state_d == state_q)
                   ? wait_cnt_q + WAIT_CNT_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RST;
            div_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       div_start;
    logic       hilo_write;
    logic       illegal_instr;
    logic       bus_error;

    int checks   = 0;
    int failures = 0;

    multicycle_control_unit #(
        .OPCODE_W    (6),
        .FUNCT_W     (6),
        .ALUOP_W     (3),
        .DIV_CYCLES  (4),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_op        (alu_op),
        .alu_src_b     (alu_src_b),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .div_start     (div_start),
        .hilo_write    (hilo_write),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] outs;
    assign outs = {pc_write, pc_src, ir_write, reg_dst, mem_to_reg, alu_op, alu_src_b,
                   mem_read, mem_write, reg_write, div_start, hilo_write, illegal_instr, bus_error};

    localparam logic [17:0] PCW      = 18'h20000;
    localparam logic [17:0] SRC_JMP  = 18'h08000;
    localparam logic [17:0] SRC_RS   = 18'h10000;
    localparam logic [17:0] SRC_PC1  = 18'h18000;
    localparam logic [17:0] IRW      = 18'h04000;
    localparam logic [17:0] RD_RD    = 18'h01000;
    localparam logic [17:0] RD_RA    = 18'h02000;
    localparam logic [17:0] M2R      = 18'h00800;
    localparam logic [17:0] A_SUB    = 18'h00100;
    localparam logic [17:0] A_AND    = 18'h00200;
    localparam logic [17:0] A_OR     = 18'h00400;
    localparam logic [17:0] A_XOR    = 18'h00500;
    localparam logic [17:0] A_FN     = 18'h00600;
    localparam logic [17:0] A_SUBN   = 18'h00700;
    localparam logic [17:0] ASB      = 18'h00080;
    localparam logic [17:0] MR       = 18'h00040;
    localparam logic [17:0] MW       = 18'h00020;
    localparam logic [17:0] RW       = 18'h00010;
    localparam logic [17:0] DS       = 18'h00008;
    localparam logic [17:0] HW       = 18'h00004;
    localparam logic [17:0] ILL      = 18'h00002;
    localparam logic [17:0] BE       = 18'h00001;
    localparam logic [17:0] FETCH_OK = PCW | SRC_PC1 | IRW | MR;

    task automatic test_reset();
        rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        checks++;
        if (outs !== 18'h0) begin
            failures++;
            $display("FAIL reset_assert got=%h exp=%h", outs, 18'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== 18'h0) begin
            failures++;
            $display("FAIL reset_rst_state got=%h exp=%h", outs, 18'h0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_four(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input logic [17:0] e2, input logic [17:0] e3);
        logic [17:0] e [4];
        e = '{FETCH_OK, 18'h0, e2, e3};
        opcode = op; funct = fn; zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%h exp=%h", nm, i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_three(input string nm, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic [17:0] e2);
        logic [17:0] e [3];
        e = '{FETCH_OK, 18'h0, e2};
        opcode = op; funct = fn; zero = z;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%h exp=%h", nm, i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        logic [17:0] e [8];
        logic        r [8];
        e = '{FETCH_OK, 18'h0, ASB, MR, MR, MR, MR, RW | M2R};
        r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 6'b100011; funct = 6'd0; zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = r[i];
            #1;
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL lw_wait cycle=%0d got=%h exp=%h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div();
        logic [17:0] e [6];
        e = '{FETCH_OK, DS, 18'h0, 18'h0, 18'h0, HW};
        opcode = 6'b000000; funct = 6'b011010; zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL div cycle=%0d got=%h exp=%h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_timeout();
        logic [17:0] e [17];
        for (int i = 0; i < 15; i++) e[i] = MR;
        e[15] = BE;
        e[16] = ILL;
        opcode = 6'b001000; funct = 6'd0; zero = 1'b0;
        for (int i = 0; i < 17; i++) begin
            mem_ready = 1'b0;
            #1;
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL fetch_timeout cycle=%0d got=%h exp=%h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ready_wins();
        logic [17:0] e [18];
        for (int i = 0; i < 15; i++) e[i] = MR;
        e[15] = FETCH_OK;
        e[16] = 18'h0;
        e[17] = PCW | SRC_JMP;
        opcode = 6'b000010; funct = 6'd0; zero = 1'b0;
        for (int i = 0; i < 18; i++) begin
            mem_ready = (i >= 15);
            #1;
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL ready_wins cycle=%0d got=%h exp=%h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_div();
        logic [17:0] e [6];
        e = '{FETCH_OK, DS, 18'h0, 18'h0, 18'h0, HW};
        opcode = 6'b000000; funct = 6'b011010; zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL reset_mid_div cycle=%0d got=%h exp=%h", i, outs, e[i]);
            end
            if (i < 5) begin
                @(posedge clk); #1;
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 18'h0) begin
            failures++;
            $display("FAIL reset_mid_div_async got=%h exp=%h", outs, 18'h0);
        end
        @(posedge clk); #1;
        checks++;
        if (outs !== 18'h0) begin
            failures++;
            $display("FAIL reset_mid_div_held got=%h exp=%h", outs, 18'h0);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== 18'h0) begin
            failures++;
            $display("FAIL reset_mid_div_rst got=%h exp=%h", outs, 18'h0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        test_four("b2b_addi", 6'b001000, 6'd0, ASB, RW | ASB);
        test_three("b2b_jal", 6'b000011, 6'd0, 1'b0, PCW | SRC_JMP | RW | RD_RA);
        test_div();
        test_four("b2b_sw", 6'b101011, 6'd0, ASB, MW);
    endtask

    initial begin
        test_reset();
        test_four("addi", 6'b001000, 6'd0, ASB, RW | ASB);
        test_four("andi", 6'b001100, 6'd0, ASB | A_AND, RW | ASB | A_AND);
        test_four("ori", 6'b001101, 6'd0, ASB | A_OR, RW | ASB | A_OR);
        test_four("xori", 6'b001110, 6'd0, ASB | A_XOR, RW | ASB | A_XOR);
        test_four("r_add", 6'b000000, 6'b100000, A_FN, RW | RD_RD | A_FN);
        test_four("mul", 6'b011100, 6'b000010, A_FN, RW | RD_RD | A_FN);
        test_four("sw", 6'b101011, 6'd0, ASB, MW);
        test_lw_wait();
        test_three("beq_z1", 6'b000100, 6'd0, 1'b1, PCW | A_SUB);
        test_three("bne_z1", 6'b000101, 6'd0, 1'b1, A_SUBN);
        test_three("bne_z0", 6'b000101, 6'd0, 1'b0, PCW | A_SUBN);
        test_three("j", 6'b000010, 6'd0, 1'b0, PCW | SRC_JMP);
        test_three("jr", 6'b000000, 6'b001000, 1'b0, PCW | SRC_RS);
        test_three("jalr", 6'b000000, 6'b001001, 1'b0, PCW | SRC_RS | RW | RD_RA);
        test_div();
        test_three("illegal_3f", 6'b111111, 6'd0, 1'b0, ILL);
        test_three("illegal_sp2", 6'b011100, 6'b000001, 1'b0, ILL);
        test_fetch_timeout();
        test_ready_wins();
        test_reset_mid_div();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
